// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/multi-cycle control for a 4-stage-valid in-order pipe.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   fetch_valid                   IF holds a valid instruction
//   id_hazard                     load-use hazard seen in ID
//   ex_branch_taken               taken branch in EX (flush request)
//   ex_mc_start, ex_mc_cycles     EX multi-cycle op and its extra cycle count
//   if_en..wb_en                  stage register load enables (combinational)
//   valid                         registered {ID,EX,MEM,WB} valid bits
//   state                         0 = RUN, 1 = MC_WAIT
//   stall_cnt, flush_cnt          saturating statistics
module pipeline_ctrl #(
    parameter int CNT_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic              id_hazard,
    input  logic              ex_branch_taken,
    input  logic              ex_mc_start,
    input  logic [CNT_W-1:0]  ex_mc_cycles,
    output logic              if_en,
    output logic              id_en,
    output logic              ex_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic [3:0]        valid,
    output logic              state,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    typedef enum logic {
        S_RUN = 1'b0,
        S_MC  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_valid;
    logic [3:0]         w_valid_nxt;
    logic [STAT_W-1:0]  r_stall_cnt;
    logic [STAT_W-1:0]  r_flush_cnt;

    logic w_run;
    logic w_br;
    logic w_mc;
    logic w_hz;
    logic w_take_br;
    logic w_take_mc;
    logic w_take_hz;

    // Requests only count when the stage that raises them holds a valid op.
    assign w_run     = (r_state == S_RUN);
    assign w_br      = ex_branch_taken & r_valid[2];
    assign w_mc      = ex_mc_start & r_valid[2] & (ex_mc_cycles != '0);
    assign w_hz      = id_hazard & r_valid[3];

    // Priority resolution: branch > multi-cycle > hazard, RUN only.
    assign w_take_br = w_run & w_br;
    assign w_take_mc = w_run & ~w_br & w_mc;
    assign w_take_hz = w_run & ~w_br & ~w_mc & w_hz;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_take_mc) begin
                    w_state_nxt = S_MC;
                end
            end
            S_MC: begin
                // Counter is loaded with N>0, so this fires after N cycles.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Output logic: enables and the next valid vector.
    always_comb begin
        if_en       = 1'b1;
        id_en       = 1'b1;
        ex_en       = 1'b1;
        mem_en      = 1'b1;
        wb_en       = 1'b1;
        w_valid_nxt = {fetch_valid, r_valid[3:1]};
        if (rst) begin
            if_en  = 1'b0;
            id_en  = 1'b0;
            ex_en  = 1'b0;
            mem_en = 1'b0;
            wb_en  = 1'b0;
        end else if (!w_run || w_take_mc) begin
            // Freeze IF/ID/EX, keep draining MEM/WB behind a bubble.
            if_en       = 1'b0;
            id_en       = 1'b0;
            ex_en       = 1'b0;
            w_valid_nxt = {r_valid[3:2], 1'b0, r_valid[1]};
        end else if (w_take_br) begin
            w_valid_nxt = {2'b00, r_valid[2:1]};
        end else if (w_take_hz) begin
            if_en       = 1'b0;
            id_en       = 1'b0;
            w_valid_nxt = {r_valid[3], 1'b0, r_valid[2:1]};
        end
    end

    // Valid bits, multi-cycle counter and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_take_mc) begin
                r_cnt <= ex_mc_cycles;
            end else if (!w_run) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (!if_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_take_br && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign valid     = r_valid;
    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vector table plus hand sequences for saturation
// and asynchronous reset during a multi-cycle wait.
module tb_pipeline_ctrl;

    localparam int CNT_W  = 4;
    localparam int STAT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_valid;
    logic              id_hazard;
    logic              ex_branch_taken;
    logic              ex_mc_start;
    logic [CNT_W-1:0]  ex_mc_cycles;
    logic              if_en, id_en, ex_en, mem_en, wb_en;
    logic [3:0]        valid;
    logic              state;
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] flush_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_valid(fetch_valid),
        .id_hazard(id_hazard),
        .ex_branch_taken(ex_branch_taken),
        .ex_mc_start(ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles),
        .if_en(if_en),
        .id_en(id_en),
        .ex_en(ex_en),
        .mem_en(mem_en),
        .wb_en(wb_en),
        .valid(valid),
        .state(state),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic       fv;
        logic       hz;
        logic       br;
        logic       mc;
        logic [3:0] cyc;
        logic [4:0] en;
        logic [3:0] val;
        logic       st;
        int         stl;
        int         fl;
    } vec_t;

    vec_t vq[$];

    function automatic logic [4:0] ens();
        return {if_en, id_en, ex_en, mem_en, wb_en};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic hz, input logic br,
                         input logic mc, input logic [3:0] cyc);
        fetch_valid     = fv;
        id_hazard       = hz;
        ex_branch_taken = br;
        ex_mc_start     = mc;
        ex_mc_cycles    = cyc;
    endtask

    // Drive at negedge, check enables before the edge, registered state after.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.fv, v.hz, v.br, v.mc, v.cyc);
        #1;
        chk($sformatf("v%0d en", idx), int'(ens()), int'(v.en));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d valid", idx), int'(valid), int'(v.val));
        chk($sformatf("v%0d state", idx), int'(state), int'(v.st));
        chk($sformatf("v%0d stall", idx), int'(stall_cnt), v.stl);
        chk($sformatf("v%0d flush", idx), int'(flush_cnt), v.fl);
    endtask

    task automatic cyc1(input logic fv, input logic hz, input logic br,
                        input logic mc, input logic [3:0] cyc);
        @(negedge clk);
        drive(fv, hz, br, mc, cyc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              fv hz br mc cyc  en        valid    st stl fl
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1000, 0, 0, 0});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1100, 0, 0, 0});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1110, 0, 0, 0});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1111, 0, 0, 0});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1111, 0, 0, 0});
        vq.push_back('{1, 0, 1, 0, 4'd0, 5'b11111, 4'b0011, 0, 0, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1001, 0, 0, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1100, 0, 0, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1110, 0, 0, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1111, 0, 0, 1});
        vq.push_back('{1, 0, 0, 1, 4'd3, 5'b00011, 4'b1101, 1, 1, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b00011, 4'b1100, 1, 2, 1});
        vq.push_back('{1, 1, 1, 1, 4'd7, 5'b00011, 4'b1100, 1, 3, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b00011, 4'b1100, 0, 4, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1110, 0, 4, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1111, 0, 4, 1});
        vq.push_back('{1, 1, 0, 0, 4'd0, 5'b00111, 4'b1011, 0, 5, 1});
        vq.push_back('{1, 1, 0, 0, 4'd0, 5'b00111, 4'b1001, 0, 6, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1100, 0, 6, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1110, 0, 6, 1});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1111, 0, 6, 1});
        vq.push_back('{1, 1, 1, 1, 4'd3, 5'b11111, 4'b0011, 0, 6, 2});
        vq.push_back('{0, 1, 1, 1, 4'd2, 5'b11111, 4'b0001, 0, 6, 2});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1000, 0, 6, 2});
        vq.push_back('{1, 0, 0, 0, 4'd0, 5'b11111, 4'b1100, 0, 6, 2});
        vq.push_back('{1, 0, 0, 1, 4'd0, 5'b11111, 4'b1110, 0, 6, 2});
        vq.push_back('{0, 0, 0, 0, 4'd0, 5'b11111, 4'b0111, 0, 6, 2});
        vq.push_back('{1, 1, 0, 0, 4'd0, 5'b11111, 4'b1011, 0, 6, 2});

        // Reset behaviour with live inputs.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        #1;
        chk("rst en", int'(ens()), 0);
        chk("rst valid", int'(valid), 0);
        chk("rst state", int'(state), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst hold valid", int'(valid), 0);
        chk("rst hold stall", int'(stall_cnt), 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;

        foreach (vq[i]) apply(vq[i], i);

        // Held hazard drives stall_cnt into saturation (6 + 12 > 15).
        for (int i = 0; i < 12; i++) cyc1(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("stall sat", int'(stall_cnt), 15);
        chk("hz hold valid", int'(valid), 'b1000);

        // Refill EX, then repeated branches push flush_cnt to saturation.
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 15; i++) begin
            cyc1(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
            cyc1(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            cyc1(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        end
        chk("flush sat", int'(flush_cnt), 15);
        chk("stall still sat", int'(stall_cnt), 15);

        // Enter MC_WAIT with N=5 and reset asynchronously between edges.
        cyc1(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        chk("mc5 state", int'(state), 1);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("mc5 wait", int'(state), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async valid", int'(valid), 0);
        chk("async state", int'(state), 0);
        chk("async stall", int'(stall_cnt), 0);
        chk("async flush", int'(flush_cnt), 0);
        chk("async en", int'(ens()), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post rst en", int'(ens()), 'b11111);
        @(posedge clk);
        #1;
        chk("post rst valid", int'(valid), 'b1000);
        for (int i = 0; i < 4; i++) begin
            cyc1(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            chk($sformatf("post rst en %0d", i), int'(ens()), 'b11111);
        end
        chk("post rst stall", int'(stall_cnt), 0);
        chk("post rst valid full", int'(valid), 'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
